// File: rtl/ps2_mouse_packet_pkg.sv
// Shared constants, state encoding and delta formatting for the PS/2 mouse packet assembler.
package ps2_mouse_packet_pkg;

  localparam logic [7:0] CMD_STREAM_EN = 8'hF4;
  localparam logic [7:0] ACK           = 8'hFA;

  localparam int SYNC = 3;
  localparam int XS   = 4;
  localparam int YS   = 5;
  localparam int XO   = 6;
  localparam int YO   = 7;

  typedef enum logic [2:0] {
    INIT_SEND,
    INIT_TX,
    INIT_ACK,
    B1,
    B2,
    B3,
    DONE
  } state_t;

  // Overflowed axes clamp to +/-255 in 9-bit two's complement.
  function automatic logic [8:0] axis_delta(input logic sign, input logic ovf,
                                            input logic [7:0] mag);
    logic [8:0] res;
    if (ovf) res = sign ? 9'h101 : 9'h0FF;
    else     res = {sign, mag};
    return res;
  endfunction

endpackage

// File: rtl/ps2_mouse_packet_gap_timer.sv
// Clear/enable up-counter with a one-cycle expire strobe every TIMEOUT_CYCLES enabled cycles.
module ps2_mouse_packet_gap_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // A clear in the same cycle suppresses expiry, so an arriving byte wins.
  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (clr || expire)   cnt <= '0;
    else if (en)              cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/ps2_mouse_packet.sv
// Enables PS/2 mouse streaming, then assembles 3-byte movement packets into deltas and buttons.
module ps2_mouse_packet
  import ps2_mouse_packet_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       tx_done_tick,
  output logic [7:0] tx_data,
  output logic       wr_ps2,
  output logic [8:0] xChange,
  output logic [8:0] yChange,
  output logic [2:0] btn,
  output logic       m_done_tick
);

  // state     | meaning
  // INIT_SEND | request transmit of 0xF4
  // INIT_TX   | wait for transmitter to finish
  // INIT_ACK  | wait for 0xFA, timed
  // B1        | wait for header byte with sync bit set, untimed
  // B2        | wait for X byte, timed
  // B3        | wait for Y byte, timed
  // DONE      | new packet presented; a byte here is treated as a header

  state_t     state, next_state;
  logic       tmr_clr, tmr_en, tmr_expire;
  logic       ld_b1, ld_b2, pkt_done;
  logic [7:0] b1, b2;

  ps2_mouse_packet_gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT_SEND;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    tmr_en     = 1'b0;
    tmr_clr    = 1'b1;
    ld_b1      = 1'b0;
    ld_b2      = 1'b0;
    pkt_done   = 1'b0;
    case (state)
      INIT_SEND: next_state = INIT_TX;
      INIT_TX:   if (tx_done_tick) next_state = INIT_ACK;
      INIT_ACK: begin
        tmr_en  = 1'b1;
        tmr_clr = rx_done_tick && (rx_data == ACK);
        if (rx_done_tick) begin
          if (rx_data == ACK) next_state = B1;
        end else if (tmr_expire) begin
          next_state = INIT_SEND;
        end
      end
      B1, DONE: begin
        if (rx_done_tick && rx_data[SYNC]) begin
          ld_b1      = 1'b1;
          next_state = B2;
        end else begin
          next_state = B1;
        end
      end
      B2: begin
        tmr_en  = 1'b1;
        tmr_clr = rx_done_tick;
        if (rx_done_tick) begin
          ld_b2      = 1'b1;
          next_state = B3;
        end else if (tmr_expire) begin
          next_state = B1;
        end
      end
      B3: begin
        tmr_en  = 1'b1;
        tmr_clr = rx_done_tick;
        if (rx_done_tick) begin
          pkt_done   = 1'b1;
          next_state = DONE;
        end else if (tmr_expire) begin
          next_state = B1;
        end
      end
      default: next_state = INIT_SEND;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1 <= '0;
      b2 <= '0;
    end else begin
      if (ld_b1) b1 <= rx_data;
      if (ld_b2) b2 <= rx_data;
    end
  end

  // The third byte feeds the output registers directly, so results appear during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data     <= CMD_STREAM_EN;
      wr_ps2      <= 1'b0;
      xChange     <= '0;
      yChange     <= '0;
      btn         <= '0;
      m_done_tick <= 1'b0;
    end else begin
      tx_data     <= CMD_STREAM_EN;
      wr_ps2      <= (state == INIT_SEND);
      m_done_tick <= pkt_done;
      if (pkt_done) begin
        btn     <= b1[2:0];
        xChange <= axis_delta(b1[XS], b1[XO], b2);
        yChange <= axis_delta(b1[YS], b1[YO], rx_data);
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Randomized scoreboard bench for ps2_mouse_packet with a behavioural packet model.
module tb_ps2_mouse_packet;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       tx_done_tick;
  logic [7:0] tx_data;
  logic       wr_ps2;
  logic [8:0] xChange, yChange;
  logic [2:0] btn;
  logic       m_done_tick;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];

  ps2_mouse_packet #(.TIMEOUT_CYCLES(100), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .tx_done_tick (tx_done_tick),
    .tx_data      (tx_data),
    .wr_ps2       (wr_ps2),
    .xChange      (xChange),
    .yChange      (yChange),
    .btn          (btn),
    .m_done_tick  (m_done_tick)
  );

  always #5 clk = ~clk;

  // Reference: signed delta is mag (sign 0) or mag-256 (sign 1); overflow clamps to +/-255.
  function automatic logic [8:0] model_axis(input logic [7:0] mag, input logic sign,
                                            input logic ovf);
    int v;
    if (ovf) v = sign ? -255 : 255;
    else     v = sign ? int'(mag) - 256 : int'(mag);
    return 9'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_done_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: got btn=%b x=%h y=%h expected no tick", btn, xChange, yChange);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({btn, xChange, yChange} !== e) begin
          errors++;
          $display("FAIL packet: got btn=%b x=%h y=%h expected btn=%b x=%h y=%h",
                   btn, xChange, yChange, e[20:18], e[17:9], e[8:0]);
        end
      end
    end
    if (rst_n && wr_ps2) check("wr_tx_data", 32'(tx_data), 32'h0F4);
  end

  // Caller is positioned at a negedge; gap 0 allows back-to-back bytes.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3,
                             input int gap);
    exp_q.push_back({p1[2:0], model_axis(p2, p1[4], p1[6]), model_axis(p3, p1[5], p1[7])});
    send_byte(p1, gap);
    send_byte(p2, gap);
    send_byte(p3, gap);
  endtask

  task automatic wait_wr(input string name, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (wr_ps2) found = 1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic pulse_tx_done();
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    check("wr_single_cycle", 32'(wr_ps2), 32'd0);
  endtask

  task automatic do_init();
    wait_wr("init_wr", 20);
    pulse_tx_done();
    send_byte(8'hAA, 2);
    send_byte(8'hFA, 2);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_done_tick = 1'b0; tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(xChange), 32'd0);
    check("rst_y", 32'(yChange), 32'd0);
    check("rst_btn", 32'(btn), 32'd0);
    check("rst_tick", 32'(m_done_tick), 32'd0);
    check("rst_wr", 32'(wr_ps2), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h0F4);
    rst_n = 1'b1;
    do_init();

    send_packet(8'h09, 8'h05, 8'hFB, 2);
    send_packet(8'h38, 8'hF0, 8'h10, 1);
    send_byte(8'h02, 2);
    send_packet(8'h08, 8'h01, 8'h02, 0);
    send_byte(8'h08, 2);
    send_byte(8'h03, 2);
    repeat (150) @(negedge clk);
    send_packet(8'h08, 8'h04, 8'h05, 2);
    send_packet(8'hD8, 8'h00, 8'h00, 2);
    send_packet(8'h48, 8'h00, 8'h00, 0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] h;
      if ($urandom_range(0, 1) == 1) begin
        h = 8'($urandom());
        h[3] = 1'b0;
        send_byte(h, $urandom_range(0, 2));
      end
      h = 8'($urandom());
      h[3] = 1'b1;
      send_packet(h, 8'($urandom()), 8'($urandom()), $urandom_range(0, 3));
    end
    repeat (5) @(negedge clk);

    // ACK timeout: no FA after the first send must trigger a resend.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_wr("ack_wr_first", 20);
    pulse_tx_done();
    wait_wr("ack_timeout_resend", 300);
    pulse_tx_done();
    send_byte(8'hFA, 2);
    send_packet(8'h09, 8'h05, 8'hFB, 1);
    repeat (5) @(negedge clk);

    send_byte(8'h08, 2);
    send_byte(8'h01, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_x", 32'(xChange), 32'd0);
    check("midrst_y", 32'(yChange), 32'd0);
    check("midrst_btn", 32'(btn), 32'd0);
    check("midrst_tick", 32'(m_done_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_init();
    send_packet(8'h1F, 8'h7F, 8'h80, 1);

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
